// File: rtl/dcache_wt_dm_pkg.sv
// Shared FSM encoding and address-field width helpers for the write-through
// direct-mapped data cache.
package dcache_wt_dm_pkg;

    localparam int DC_LINES = 16;
    localparam int DC_WPL   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE,
        S_WDONE
    } state_t;

    function automatic int ofs_w(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int wpl);
        return 30 - $clog2(lines) - $clog2(wpl);
    endfunction

endpackage

// File: rtl/dcache_wt_dm_array.sv
// Purpose: valid/tag/data storage for the direct-mapped cache.
// Latency: combinational read port, writes take effect at the next core_clk edge.
// Backpressure: none; the controller sequences all writes.
module dcache_wt_dm_array
    import dcache_wt_dm_pkg::*;
#(
    parameter int  LINES = DC_LINES,
    parameter int  WPL   = DC_WPL,
    localparam int OFS_W = ofs_w(WPL),
    localparam int IDX_W = idx_w(LINES),
    localparam int TAG_W = tag_w(LINES, WPL)
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFS_W-1:0] rd_ofs,
    output logic             rd_line_vld,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_dat,
    input  logic             wr_vld,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFS_W-1:0] wr_ofs,
    input  logic [31:0]      wr_dat,
    input  logic             set_line_vld,
    input  logic [TAG_W-1:0] set_tag
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WPL];

    assign rd_line_vld = valid_q[rd_idx];
    assign rd_tag      = tag_q[rd_idx];
    assign rd_dat      = data_q[rd_idx][rd_ofs];

    // Only the valid bits are reset; a line is never trusted until a full refill.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= '0;
        end else if (set_line_vld) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (wr_vld) begin
            data_q[wr_idx][wr_ofs] <= wr_dat;
        end
        if (set_line_vld) begin
            tag_q[wr_idx] <= set_tag;
        end
    end

endmodule

// File: rtl/dcache_wt_dm.sv
// Purpose: direct-mapped write-through no-write-allocate data cache for the MEM stage.
// Latency: read hit 0 cycles; read miss WPL memory acks + 1; store 1 + N_mem + 1.
// Backpressure: cpu_stall holds the pipeline; memory side waits on one mem_ack per word.
module dcache_wt_dm
    import dcache_wt_dm_pkg::*;
#(
    parameter int LINES = DC_LINES,
    parameter int WPL   = DC_WPL
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int OFS_W = ofs_w(WPL);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES, WPL);
    localparam logic [OFS_W-1:0] LAST_WORD = OFS_W'(WPL - 1);

    state_t           state;
    logic [OFS_W-1:0] cnt;
    logic [OFS_W-1:0] cnt_nxt;
    logic [TAG_W-1:0] ref_tag;
    logic [IDX_W-1:0] ref_idx;

    logic [OFS_W-1:0] a_ofs;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;

    logic             line_vld;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_dat;
    logic             hit;
    logic             read_hit;
    logic             refill_wr;
    logic             store_hit;
    logic             arr_wr_vld;
    logic [IDX_W-1:0] arr_wr_idx;
    logic [OFS_W-1:0] arr_wr_ofs;
    logic [31:0]      arr_wr_dat;
    logic             arr_set_vld;
    logic             stall_raw;

    assign a_ofs   = cpu_addr[OFS_W+1:2];
    assign a_idx   = cpu_addr[IDX_W+OFS_W+1:OFS_W+2];
    assign a_tag   = cpu_addr[31:IDX_W+OFS_W+2];
    assign cnt_nxt = cnt + OFS_W'(1);

    dcache_wt_dm_array #(
        .LINES (LINES),
        .WPL   (WPL)
    ) u_array (
        .core_clk     (CLK),
        .arst_n       (RESET),
        .rd_idx       (a_idx),
        .rd_ofs       (a_ofs),
        .rd_line_vld  (line_vld),
        .rd_tag       (line_tag),
        .rd_dat       (line_dat),
        .wr_vld       (arr_wr_vld),
        .wr_idx       (arr_wr_idx),
        .wr_ofs       (arr_wr_ofs),
        .wr_dat       (arr_wr_dat),
        .set_line_vld (arr_set_vld),
        .set_tag      (ref_tag)
    );

    assign hit      = line_vld && (line_tag == a_tag);
    assign read_hit = (state == S_IDLE) && cpu_read && !cpu_write && hit;

    // Refill words come from the latched line; store hits patch the addressed word.
    assign refill_wr   = (state == S_REFILL) && mem_req && mem_ack;
    assign store_hit   = (state == S_IDLE) && cpu_write && hit;
    assign arr_wr_vld  = refill_wr || store_hit;
    assign arr_wr_idx  = refill_wr ? ref_idx   : a_idx;
    assign arr_wr_ofs  = refill_wr ? cnt       : a_ofs;
    assign arr_wr_dat  = refill_wr ? mem_rdata : cpu_wdata;
    assign arr_set_vld = refill_wr && (cnt == LAST_WORD);

    assign cpu_rdata = read_hit ? line_dat : 32'h0;

    always_comb begin
        stall_raw = 1'b0;
        case (state)
            S_IDLE:   stall_raw = cpu_write || (cpu_read && !hit);
            S_REFILL: stall_raw = 1'b1;
            S_WRITE:  stall_raw = 1'b1;
            S_WDONE:  stall_raw = 1'b0;
            default:  stall_raw = 1'b0;
        endcase
    end

    // Held low during reset so the pipeline is never frozen by stale array state.
    assign cpu_stall = RESET && stall_raw;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ref_tag   <= '0;
            ref_idx   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_write) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[31:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                        state     <= S_WRITE;
                    end else if (cpu_read && !hit) begin
                        ref_tag  <= a_tag;
                        ref_idx  <= a_idx;
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {a_tag, a_idx, {OFS_W{1'b0}}, 2'b00};
                        state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        cnt      <= cnt_nxt;
                        mem_addr <= {ref_tag, ref_idx, cnt_nxt, 2'b00};
                        if (cnt == LAST_WORD) begin
                            mem_req <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_WDONE;
                    end
                end
                S_WDONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wt_dm.sv
// Bench for dcache_wt_dm: directed vector table, reset corner cases and random
// traffic against a line-tag/memory reference model with a latency-programmable memory.
module tb_dcache_wt_dm;

    localparam int WPL   = 4;
    localparam int LIMIT = 200;

    logic        CLK;
    logic        RESET;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    dcache_wt_dm dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Backing memory seen by the DUT, and the bench's own idea of memory contents.
    logic [31:0] mem     [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    int          model_tag [16];
    logic [31:0] rd_log [$];
    int          wr_cnt    = 0;
    int          ack_cnt   = 0;
    int          req_rises = 0;
    int          ack_delay = 2;
    logic        req_prev  = 1'b0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5EED_0000;
    endfunction

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Memory responder: ack after ack_delay cycles of mem_req per word.
    initial begin
        int wait_c;
        wait_c    = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge CLK);
            mem_ack = 1'b0;
            if (mem_req && !req_prev) req_rises++;
            req_prev = mem_req;
            if (RESET && mem_req) begin
                wait_c++;
                if (wait_c >= ack_delay) begin
                    wait_c  = 0;
                    mem_ack = 1'b1;
                    ack_cnt++;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wr_cnt++;
                    end else begin
                        mem_rdata = mem_get(mem_addr);
                        rd_log.push_back(mem_addr);
                    end
                end
            end else begin
                wait_c = 0;
            end
        end
    end

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int st);
        @(negedge CLK);
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = a;
        cpu_wdata = $urandom;
        #1;
        st = 0;
        while (cpu_stall && st < LIMIT) begin
            @(negedge CLK);
            #1;
            st++;
        end
        d = cpu_rdata;
        @(posedge CLK);
        #1;
        cpu_read = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] w,
                             output int st, output logic req_wdone);
        @(negedge CLK);
        cpu_write = 1'b1;
        cpu_read  = 1'($urandom_range(0, 1));
        cpu_addr  = a;
        cpu_wdata = w;
        #1;
        st = 0;
        while (cpu_stall && st < LIMIT) begin
            @(negedge CLK);
            #1;
            st++;
        end
        req_wdone = mem_req;
        @(posedge CLK);
        #1;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
    endtask

    task automatic do_op(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit exp_hit, input string nm);
        int          st;
        int          rr0;
        int          wr0;
        logic [31:0] d;
        logic        rq;
        logic [31:0] base;
        logic [31:0] wa;
        rd_log.delete();
        rr0  = req_rises;
        wr0  = wr_cnt;
        base = {addr[31:4], 4'h0};
        wa   = {addr[31:2], 2'b00};
        if (is_wr) begin
            bus_write(addr, wdata, st, rq);
            check({nm, " store_stall"}, st, 1 + ack_delay);
            check({nm, " wdone_req"}, 32'(rq), 0);
            check({nm, " mem_writes"}, wr_cnt - wr0, 1);
            check({nm, " mem_word"}, mem_get(wa), wdata);
            check({nm, " req_trains"}, req_rises - rr0, 1);
            ref_mem[wa] = wdata;
        end else begin
            bus_read(addr, d, st);
            check({nm, " rdata"}, d, exp_rd);
            check({nm, " read_stall"}, st, exp_hit ? 0 : 1 + WPL * ack_delay);
            check({nm, " mem_reads"}, rd_log.size(), exp_hit ? 0 : WPL);
            check({nm, " req_trains"}, req_rises - rr0, exp_hit ? 0 : 1);
            if (!exp_hit && rd_log.size() == WPL) begin
                for (int i = 0; i < WPL; i++)
                    check($sformatf("%s word%0d_addr", nm, i), rd_log[i], base + 32'(4 * i));
            end
            if (!exp_hit) model_tag[addr[7:4]] = int'(addr[31:8]);
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_hit;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          a0;
        logic [31:0] a;
        bit          wr;

        tbl[0] = '{0, 32'h0000_0040, 32'h0,         32'h0000_00A0, 0};
        tbl[1] = '{0, 32'h0000_004C, 32'h0,         32'h0000_00A3, 1};
        tbl[2] = '{0, 32'h0000_0140, 32'h0,         dflt(32'h140), 0};
        tbl[3] = '{0, 32'h0000_0040, 32'h0,         32'h0000_00A0, 0};
        tbl[4] = '{1, 32'h0000_0044, 32'hDEAD_BEEF, 32'h0,         0};
        tbl[5] = '{0, 32'h0000_0044, 32'h0,         32'hDEAD_BEEF, 1};
        tbl[6] = '{1, 32'h0000_0380, 32'h1234_5678, 32'h0,         0};
        tbl[7] = '{0, 32'h0000_0380, 32'h0,         32'h1234_5678, 0};

        for (int i = 0; i < 4; i++) begin
            mem[32'h40 + 32'(4 * i)]     = 32'hA0 + 32'(i);
            ref_mem[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
        end
        for (int i = 0; i < 16; i++) model_tag[i] = -1;

        // Reset state, with a read held high to show the stall is suppressed.
        RESET     = 1'b0;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 32'h40;
        cpu_wdata = 32'h0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst cpu_stall", 32'(cpu_stall), 0);
        check("rst mem_req", 32'(mem_req), 0);
        check("rst mem_we", 32'(mem_we), 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst cpu_rdata", cpu_rdata, 0);
        cpu_read = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;

        ack_delay = 2;
        for (int i = 0; i < 8; i++)
            do_op(tbl[i].is_wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_hit,
                  $sformatf("vec%0d", i));

        // Reset after two refill words: request drops at once and the line stays invalid.
        a0 = ack_cnt;
        @(negedge CLK);
        cpu_read = 1'b1;
        cpu_addr = 32'h600;
        n = 0;
        while ((ack_cnt - a0) < 2 && n < LIMIT) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("rstmid acks", ack_cnt - a0, 2);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("rstmid mem_req", 32'(mem_req), 0);
        check("rstmid cpu_stall", 32'(cpu_stall), 0);
        @(negedge CLK);
        cpu_read = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 16; i++) model_tag[i] = -1;
        do_op(0, 32'h600, 32'h0, ref_get(32'h600), 0, "rstmid refetch");
        do_op(0, 32'h604, 32'h0, ref_get(32'h604), 1, "rstmid rehit");
        do_op(0, 32'h44, 32'h0, 32'hDEAD_BEEF, 0, "rstmid cleared");

        // Random traffic over a few tags/indices so hits, conflicts and store hits mix.
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) |
                ($urandom_range(0, 3) << 2);
            wr = ($urandom_range(0, 2) == 0);
            ack_delay = int'($urandom_range(1, 3));
            do_op(wr, a, $urandom, ref_get(a), model_tag[a[7:4]] == int'(a[31:8]),
                  $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcache_wt_dm.md
Name: dcache_wt_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the MEM stage (EX/MEM outputs: address, store data, MemRead, MemWrite) and a slower word-wide main memory.
- Replaces the single-cycle Data_memory path. Stalls the pipeline through `cpu_stall` on read misses and on every store.

Parameters:
- LINES, 16, number of cache lines (power of two).
- WPL, 4, 32-bit words per line (power of two).
- Derived: OFS_W = log2(WPL) = 2; IDX_W = log2(LINES) = 4; TAG_W = 30 - IDX_W - OFS_W = 24.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- cpu_read  in  1  MemRead from EX/MEM.
- cpu_write  in  1  MemWrite from EX/MEM.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned address, [1:0] = 0.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse per word.

Behaviour:
- Address split: offset = addr[OFS_W+1:2]; index = addr[IDX_W+OFS_W+1:OFS_W+2]; tag = addr[31:IDX_W+OFS_W+2].
- Storage: valid[LINES], tag[LINES], data[LINES][WPL]. Reset clears only valid. Tag and data arrays have no reset.
- hit = valid[index] && tag[index] == tag(cpu_addr).
- FSM states:
  - IDLE.
  - REFILL: word counter cnt, OFS_W bits.
  - WRITE.
  - WDONE.
- IDLE:
  - cpu_write has priority when cpu_read and cpu_write are both 1.
  - Write: on a hit, update data[index][offset] at this edge. On a miss, leave the cache unchanged. Latch addr/wdata; go to WRITE. cpu_stall = 1 combinationally.
  - Read hit: cpu_rdata = data[index][offset] combinationally, cpu_stall = 0, zero extra latency.
  - Read miss: cpu_stall = 1; latch the line base address; cnt ← 0; go to REFILL.
  - No request: cpu_stall = 0.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = {tag, index, cnt, 2'b00}. Words are fetched in order from word 0.
  - On each mem_ack: data[index][cnt] ← mem_rdata, cnt++.
  - On the ack with cnt = WPL-1: valid[index] ← 1, tag[index] ← latched tag; go to IDLE. The retried read then hits in the following cycle.
  - cpu_stall = 1 throughout.
- WRITE:
  - mem_req = 1, mem_we = 1, mem_addr/mem_wdata are the latched values, held stable until mem_ack.
  - On mem_ack go to WDONE.
  - cpu_stall = 1.
- WDONE:
  - cpu_stall = 0 for exactly one cycle, so the pipeline advances past the store. mem_req = 0.
  - Go to IDLE. The store is never re-issued even though cpu_write is still high in this cycle.
- mem_req remains asserted across consecutive REFILL words. mem_ack while mem_req = 0 is ignored.
- The same-cycle mem_ack that completes a refill and a fresh request cannot conflict: the request is evaluated only in IDLE.
- Reset values (also while RESET = 0): state IDLE, cnt 0, all valid 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0 when not a read hit, cpu_stall 0.
- Reset mid-REFILL: the line stays invalid, mem_req drops immediately (asynchronously), and a partially written line is never marked valid.
- cpu_addr, cpu_read, cpu_write and cpu_wdata are required stable while cpu_stall = 1. The cache uses its latched copies regardless.
- Store latency to the pipeline: 1 + N_mem + 1 cycles, where N_mem is the number of cycles until mem_ack. Read-miss latency: sum of the WPL memory acks + 1.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, REFILL, WRITE, WDONE).
  - Address-field width constants derived from LINES and WPL.
- One sub-module, dcache_wt_dm_array: valid/tag/data storage with one combinational read port and one synchronous write port, plus the async-reset valid clear.
- FSM, latches and memory handshake stay in the top module.

Test Plan:
- Cold read: reset, cpu_read @0x00000040, memory returns 0xA0..0xA3 with 2-cycle acks → cpu_stall high; 4 mem reads @0x40, 0x44, 0x48, 0x4C; then cpu_rdata = 0xA0, stall 0.
- Read hit: after the cold read, cpu_read @0x0000004C → cpu_rdata = 0xA3 same cycle, mem_req stays 0.
- Conflict miss: cpu_read @0x00000140 (same index, tag 0x000001) → refill; a later read @0x40 misses again.
- Store hit: cpu_write @0x44, data 0xDEADBEEF → mem write @0x44, stall released after the WDONE cycle, exactly one mem_req pulse train; a read @0x44 then hits with 0xDEADBEEF.
- Store miss: cpu_write @0x00000380 → memory written, valid[8] stays 0, and a following read @0x380 misses.
- Reset during REFILL after 2 acks → mem_req 0 immediately, and a read of the same line misses and refetches from word 0.
